// File: rtl/decode_stage.sv
// decode_stage: registered RV32I(+M) decode stage with valid/ready handshake, flush and saturating illegal counter
module decode_stage #(
   parameter int DATA_W = 32,
   parameter int EN_M   = 0,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       in_instr,
   input  logic [DATA_W-1:0] in_pc,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_pc,
   output logic [5:0]        out_op,
   output logic [4:0]        out_rd,
   output logic [4:0]        out_rs1,
   output logic [4:0]        out_rs2,
   output logic [DATA_W-1:0] out_imm,
   output logic              out_rd_we,
   output logic              out_rs1_used,
   output logic              out_rs2_used,
   output logic              out_illegal,
   output logic [CNT_W-1:0]  illegal_cnt
);
   logic [6:0]        w_opc, w_f7;
   logic [2:0]        w_f3;
   logic [5:0]        w_op;
   logic [31:0]       w_imm32, w_imm_i;
   logic              w_rd_we, w_rs1_used, w_rs2_used, w_illegal, w_accept;
   logic              r_valid, r_rd_we, r_rs1_used, r_rs2_used, r_illegal;
   logic [DATA_W-1:0] r_pc, r_imm;
   logic [5:0]        r_op;
   logic [4:0]        r_rd, r_rs1, r_rs2;
   logic [CNT_W-1:0]  r_cnt;
   assign w_opc    = in_instr[6:0];
   assign w_f3     = in_instr[14:12];
   assign w_f7     = in_instr[31:25];
   assign w_imm_i  = {{20{in_instr[31]}}, in_instr[31:20]};
   assign in_ready = !r_valid || out_ready;
   assign w_accept = in_valid && in_ready && !flush;
   always_comb begin
      w_op = 6'd63;
      w_imm32 = '0;
      w_rd_we = 1'b0;
      w_rs1_used = 1'b0;
      w_rs2_used = 1'b0;
      case (w_opc)
         7'b0110111: begin w_op = 6'd0; w_imm32 = {in_instr[31:12], 12'b0}; w_rd_we = 1'b1; end
         7'b0010111: begin w_op = 6'd1; w_imm32 = {in_instr[31:12], 12'b0}; w_rd_we = 1'b1; end
         7'b1101111: begin
            w_op = 6'd2;
            w_imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
            w_rd_we = 1'b1;
         end
         7'b1100111: begin
            w_op = (w_f3 == 3'd0) ? 6'd3 : 6'd63;
            w_imm32 = w_imm_i;
            w_rd_we = 1'b1;
            w_rs1_used = 1'b1;
         end
         7'b1100011: begin
            w_op = (w_f3[2:1] == 2'b01) ? 6'd63
                 : 6'd4 + (w_f3[2] ? {4'd0, w_f3[1:0]} + 6'd2 : {5'd0, w_f3[0]});
            w_imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
            w_rs1_used = 1'b1;
            w_rs2_used = 1'b1;
         end
         7'b0000011: begin
            w_op = (w_f3 == 3'b011 || w_f3[2:1] == 2'b11) ? 6'd63
                 : w_f3[2] ? 6'd13 + {5'd0, w_f3[0]} : 6'd10 + {4'd0, w_f3[1:0]};
            w_imm32 = w_imm_i;
            w_rd_we = 1'b1;
            w_rs1_used = 1'b1;
         end
         7'b0100011: begin
            w_op = (w_f3 < 3'd3) ? 6'd15 + {3'd0, w_f3} : 6'd63;
            w_imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            w_rs1_used = 1'b1;
            w_rs2_used = 1'b1;
         end
         7'b0010011: begin
            w_op = (w_f3 == 3'b001) ? ((w_f7 == 7'h00) ? 6'd24 : 6'd63)
                 : (w_f3 == 3'b101) ? ((w_f7 == 7'h00) ? 6'd25 : (w_f7 == 7'h20) ? 6'd26 : 6'd63)
                 : (w_f3 == 3'b000) ? 6'd18
                 : (&w_f3[2:1]) ? 6'd16 + {3'd0, w_f3} : 6'd17 + {3'd0, w_f3};
            w_imm32 = (w_f3[1:0] == 2'b01) ? {27'd0, in_instr[24:20]} : w_imm_i;
            w_rd_we = 1'b1;
            w_rs1_used = 1'b1;
         end
         7'b0110011: begin
            w_op = (w_f7 == 7'h00) ? ((w_f3 == 3'd0) ? 6'd27 : (&w_f3[2:1]) ? 6'd29 + {3'd0, w_f3} : 6'd28 + {3'd0, w_f3})
                 : (w_f7 == 7'h20) ? ((w_f3 == 3'd0) ? 6'd28 : (w_f3 == 3'd5) ? 6'd34 : 6'd63)
                 : (w_f7 == 7'h01 && EN_M != 0) ? 6'd40 + {3'd0, w_f3} : 6'd63;
            w_rd_we = 1'b1;
            w_rs1_used = 1'b1;
            w_rs2_used = 1'b1;
         end
         7'b0001111: w_op = 6'd37;
         7'b1110011: w_op = (in_instr == 32'h0000_0073) ? 6'd38 : (in_instr == 32'h0010_0073) ? 6'd39 : 6'd63;
         default: w_op = 6'd63;
      endcase
      w_illegal = (w_op == 6'd63);
      if (w_illegal) begin
         w_imm32 = '0;
         w_rd_we = 1'b0;
         w_rs1_used = 1'b0;
         w_rs2_used = 1'b0;
      end
      w_rd_we = w_rd_we && (in_instr[11:7] != 5'd0);
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_pc <= '0;
         r_op <= 6'd63;
         r_rd <= '0;
         r_rs1 <= '0;
         r_rs2 <= '0;
         r_imm <= '0;
         r_rd_we <= 1'b0;
         r_rs1_used <= 1'b0;
         r_rs2_used <= 1'b0;
         r_illegal <= 1'b0;
      end else if (flush) begin
         r_valid <= 1'b0;
      end else if (w_accept) begin
         r_valid <= 1'b1;
         r_pc <= in_pc;
         r_op <= w_op;
         r_rd <= in_instr[11:7];
         r_rs1 <= in_instr[19:15];
         r_rs2 <= in_instr[24:20];
         r_imm <= DATA_W'($signed(w_imm32));
         r_rd_we <= w_rd_we;
         r_rs1_used <= w_rs1_used;
         r_rs2_used <= w_rs2_used;
         r_illegal <= w_illegal;
      end else if (out_ready) begin
         r_valid <= 1'b0;
      end
   end
   // a flushed bundle never reaches downstream, so it is not counted
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_cnt <= '0;
      else if (r_valid && out_ready && r_illegal && !flush && !(&r_cnt)) r_cnt <= r_cnt + 1'b1;
   end
   assign out_valid    = r_valid;
   assign out_pc       = r_pc;
   assign out_op       = r_op;
   assign out_rd       = r_rd;
   assign out_rs1      = r_rs1;
   assign out_rs2      = r_rs2;
   assign out_imm      = r_imm;
   assign out_rd_we    = r_rd_we;
   assign out_rs1_used = r_rs1_used;
   assign out_rs2_used = r_rs2_used;
   assign out_illegal  = r_illegal;
   assign illegal_cnt  = r_cnt;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed checks of decode_stage with EN_M=0 and EN_M=1 instances
module tb_decode_stage;
   logic        clk = 1'b0, rst = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
   logic [31:0] in_instr = '0, in_pc = '0;
   logic        in_ready, out_valid, out_rd_we, out_rs1_used, out_rs2_used, out_illegal;
   logic [31:0] out_pc, out_imm;
   logic [5:0]  out_op;
   logic [4:0]  out_rd, out_rs1, out_rs2;
   logic [15:0] illegal_cnt;
   logic        m_in_ready, m_valid, m_rd_we, m_rs1_used, m_rs2_used, m_illegal;
   logic [31:0] m_pc, m_imm;
   logic [5:0]  m_op;
   logic [4:0]  m_rd, m_rs1, m_rs2;
   logic [15:0] m_cnt;
   int checks = 0, errors = 0;
   decode_stage #(.DATA_W(32), .EN_M(0), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
      .out_pc(out_pc), .out_op(out_op), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
      .out_imm(out_imm), .out_rd_we(out_rd_we), .out_rs1_used(out_rs1_used),
      .out_rs2_used(out_rs2_used), .out_illegal(out_illegal), .illegal_cnt(illegal_cnt));
   decode_stage #(.DATA_W(32), .EN_M(1), .CNT_W(16)) dut_m (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(m_in_ready),
      .in_instr(in_instr), .in_pc(in_pc), .out_valid(m_valid), .out_ready(out_ready),
      .out_pc(m_pc), .out_op(m_op), .out_rd(m_rd), .out_rs1(m_rs1), .out_rs2(m_rs2),
      .out_imm(m_imm), .out_rd_we(m_rd_we), .out_rs1_used(m_rs1_used),
      .out_rs2_used(m_rs2_used), .out_illegal(m_illegal), .illegal_cnt(m_cnt));
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic send(input logic [31:0] ins);
      in_valid = 1'b1;
      in_instr = ins;
      tick();
      in_valid = 1'b0;
      in_pc = in_pc + 32'd4;
   endtask
   initial begin
      #1 rst = 1'b1;
      tick();
      chk("rst_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_op", {26'd0, out_op}, 32'd63);
      chk("rst_cnt", {16'd0, illegal_cnt}, 32'd0);
      chk("rst_imm", out_imm, 32'd0);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      @(negedge clk) rst = 1'b0;
      in_pc = 32'h100;
      send(32'h0000_0000);
      chk("zero_illegal", {31'd0, out_illegal}, 32'd1);
      chk("zero_op", {26'd0, out_op}, 32'd63);
      chk("zero_cnt_pending", {16'd0, illegal_cnt}, 32'd0);
      send(32'h0220_81B3);
      chk("mul_m0_illegal", {31'd0, out_illegal}, 32'd1);
      chk("mul_m0_rd_we", {31'd0, out_rd_we}, 32'd0);
      chk("mul_m1_op", {26'd0, m_op}, 32'd40);
      chk("mul_m1_rd", {27'd0, m_rd}, 32'd3);
      chk("mul_m1_rs1", {27'd0, m_rs1}, 32'd1);
      chk("mul_m1_rs2", {27'd0, m_rs2}, 32'd2);
      chk("mul_m1_illegal", {31'd0, m_illegal}, 32'd0);
      tick();
      chk("idle_valid", {31'd0, out_valid}, 32'd0);
      chk("cnt_two", {16'd0, illegal_cnt}, 32'd2);
      in_pc = 32'h200;
      send(32'hFFF1_0093);
      chk("addi_valid", {31'd0, out_valid}, 32'd1);
      chk("addi_pc", out_pc, 32'h200);
      chk("addi_op", {26'd0, out_op}, 32'd18);
      chk("addi_rd", {27'd0, out_rd}, 32'd1);
      chk("addi_rs1", {27'd0, out_rs1}, 32'd2);
      chk("addi_imm", out_imm, 32'hFFFF_FFFF);
      chk("addi_rd_we", {31'd0, out_rd_we}, 32'd1);
      chk("addi_rs1_used", {31'd0, out_rs1_used}, 32'd1);
      chk("addi_rs2_used", {31'd0, out_rs2_used}, 32'd0);
      send(32'h4020_D093);
      chk("srai_op", {26'd0, out_op}, 32'd26);
      chk("srai_imm", out_imm, 32'd2);
      send(32'h4020_C093);
      chk("xori_op", {26'd0, out_op}, 32'd21);
      chk("xori_imm", out_imm, 32'h402);
      send(32'h0000_0013);
      chk("addi_x0_op", {26'd0, out_op}, 32'd18);
      chk("addi_x0_rd_we", {31'd0, out_rd_we}, 32'd0);
      send(32'h0020_A223);
      chk("sw_op", {26'd0, out_op}, 32'd17);
      chk("sw_imm", out_imm, 32'd4);
      chk("sw_rs2_used", {31'd0, out_rs2_used}, 32'd1);
      chk("sw_rd_we", {31'd0, out_rd_we}, 32'd0);
      send(32'h0000_0073);
      chk("ecall_op", {26'd0, out_op}, 32'd38);
      send(32'h0010_0073);
      chk("ebreak_op", {26'd0, out_op}, 32'd39);
      send(32'h0020_0073);
      chk("sys_bad_illegal", {31'd0, out_illegal}, 32'd1);
      chk("sys_bad_op", {26'd0, out_op}, 32'd63);
      tick();
      chk("cnt_three", {16'd0, illegal_cnt}, 32'd3);
      out_ready = 1'b0;
      send(32'hFFF1_0093);
      in_valid = 1'b1;
      in_instr = 32'h1234_50B7;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
         chk("hold_valid", {31'd0, out_valid}, 32'd1);
         chk("hold_op", {26'd0, out_op}, 32'd18);
         chk("hold_imm", out_imm, 32'hFFFF_FFFF);
      end
      out_ready = 1'b1;
      #1;
      chk("release_in_ready", {31'd0, in_ready}, 32'd1);
      tick();
      in_valid = 1'b0;
      chk("lui_valid", {31'd0, out_valid}, 32'd1);
      chk("lui_op", {26'd0, out_op}, 32'd0);
      chk("lui_imm", out_imm, 32'h1234_5000);
      chk("lui_rd", {27'd0, out_rd}, 32'd1);
      tick();
      chk("lui_done", {31'd0, out_valid}, 32'd0);
      out_ready = 1'b0;
      send(32'h0000_0000);
      chk("pre_flush_valid", {31'd0, out_valid}, 32'd1);
      flush = 1'b1;
      in_valid = 1'b1;
      in_instr = 32'hFFF1_0093;
      tick();
      chk("flush_valid", {31'd0, out_valid}, 32'd0);
      chk("flush_cnt", {16'd0, illegal_cnt}, 32'd3);
      flush = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      tick();
      chk("post_flush_valid", {31'd0, out_valid}, 32'd0);
      chk("post_flush_cnt", {16'd0, illegal_cnt}, 32'd3);
      out_ready = 1'b0;
      send(32'hFFF1_0093);
      chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_valid", {31'd0, out_valid}, 32'd0);
      chk("async_rst_op", {26'd0, out_op}, 32'd63);
      chk("async_rst_cnt", {16'd0, illegal_cnt}, 32'd0);
      @(negedge clk) rst = 1'b0;
      tick();
      chk("after_rst_valid", {31'd0, out_valid}, 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
